lfsr16_tracker: RTL and testbench
=================================

// Module: lfsr16_tracker
// PURPOSE
//  Receive-side companion of the 16-state augmented LFSR (lfsr16). Samples its
//  5-bit output stream, maps each code to a binary sequence index 0..15 and
//  checks that every sample is the legal successor of the previous one.
//  Runs a HUNT/CHECK/LOCKED FSM and counts sequence errors.
//  Used wherever an lfsr16 count must be read back as a binary position or audited.
// PARAMETERS
//  LOCK_CNT  2  consecutive correct successors needed to enter LOCKED (1..7)
//  MISS_MAX  3  consecutive mismatches in LOCKED before dropping to HUNT (1..7)
//  ERRW      8  width of saturating error counter
// PORTS
//  clk      in   1     clock, rising edge
//  rst      in   1     asynchronous, active-high reset
//  en       in   1     din is valid this cycle; sample is accepted
//  din      in   5     LFSR code (lfsr16 dout)
//  clr      in   1     synchronous clear of err_cnt
//  idx      out  4     binary index of last accepted legal code
//  idx_vld  out  1     1-cycle pulse: idx updated from a legal code
//  locked   out  1     FSM in LOCKED
//  err      out  1     1-cycle pulse: sequence error detected in LOCKED
//  err_cnt  out  ERRW  saturating count of err pulses
// BEHAVIOUR
//  Reset (async): idx=0, idx_vld=0, locked=0, err=0, err_cnt=0, prev=5'b10000,
//   good=0, miss=0, state=HUNT. All outputs registered; latency 1 cycle from en.
//  Code map (index:code): 0:10000 1:00001 2:00011 3:00111 4:01111 5:11110
//   6:11101 7:11010 8:10101 9:01011 10:10110 11:01100 12:11001 13:10010
//   14:00100 15:01000. Other 16 codes are illegal.
//  succ(c) = {c[3:0], c[3]^c[0]^~|c[2:0]}; succ(01000)=10000 (wrap 15->0).
//  en=0: no state change; idx holds; idx_vld, err low.
//  en=1, legal din: idx<=map(din), idx_vld<=1, prev<=din. Illegal: idx holds,
//   idx_vld<=0, prev unchanged.
//  match = legal(din) && din==succ(prev).
//  HUNT: legal -> CHECK, good=0. Illegal -> stay.
//  CHECK: match -> good+1; good+1==LOCK_CNT -> LOCKED, miss=0.
//   Legal non-match -> stay CHECK, good=0 (re-anchor on din). Illegal -> HUNT.
//  LOCKED: match -> miss=0. Non-match (incl. illegal) -> err<=1, miss+1;
//   miss+1==MISS_MAX -> HUNT, locked<=0 next cycle. Repeated code = mismatch.
//  Upstream write (wen jump) appears as one mismatch; lock kept if MISS_MAX>1.
//  err_cnt: +1 per err pulse, saturates at all-ones. clr alone -> 0;
//   clr with new error same cycle -> 1.
//  Reset mid-operation: immediate return to reset values regardless of state.
// STRUCTURE
//  lfsr16_defs.vh: state encodings (HUNT/CHECK/LOCKED), RESET_CODE 5'b10000,
//   LFSR width 5, index width 4.
//  Sub-module lfsr16_lut: combinational din -> {legal, idx[3:0], succ[4:0]}.
//  Top: sample regs, FSM, good/miss counters, err_cnt.
// TESTING
//  Reset, then en=1 with 10000,00001,00011 -> idx 0,1,2; locked=1 one cycle
//   after 00011 accepted; err=0.
//  Feed full 16-code cycle twice through 01000->10000 -> idx 15 then 0, no err.
//  Locked; inject 11111 -> idx holds, idx_vld=0, err=1, err_cnt=1; resume
//   correct successor -> miss cleared, still locked.
//  Locked; 3 mismatches in a row -> err_cnt+3, locked=0 after 3rd; 2 correct
//   successors -> relock.
//  err_cnt at all-ones + error -> stays all-ones; clr with error same cycle -> 1.
//  Assert rst mid-LOCKED between edges -> outputs zero immediately, state HUNT;
//   drive lfsr16 DUT alongside and check idx tracks its position.

Source files
------------

// File: rtl/lfsr16_tracker_pkg.sv
// Shared definitions for the lfsr16 receive-side tracker: widths, reset code,
// FSM states, LUT result record and the successor function.
package lfsr16_tracker_pkg;

  localparam int unsigned LFSR_W = 5;
  localparam int unsigned IDX_W  = 4;

  localparam logic [LFSR_W-1:0] RESET_CODE = 5'b10000;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_t;

  typedef struct packed {
    logic              legal;
    logic [IDX_W-1:0]  idx;
    logic [LFSR_W-1:0] succ;
  } lut_t;

  // Augmented-LFSR step; the all-zero-tail term closes the 16-state loop.
  function automatic logic [LFSR_W-1:0] lfsr_succ(input logic [LFSR_W-1:0] c);
    return {c[3:0], c[3] ^ c[0] ^ (~|c[2:0])};
  endfunction

endpackage

// File: rtl/lfsr16_tracker_if.sv
// Sample/result bundle between an lfsr16 stream source and the tracker.
interface lfsr16_tracker_if
  import lfsr16_tracker_pkg::*;
#(
  parameter int unsigned ERRW = 8
);

  logic              en;
  logic [LFSR_W-1:0] din;
  logic              clr;
  logic [IDX_W-1:0]  idx;
  logic              idx_vld;
  logic              locked;
  logic              err;
  logic [ERRW-1:0]   err_cnt;

  modport master (
    output en, din, clr,
    input  idx, idx_vld, locked, err, err_cnt
  );

  modport slave (
    input  en, din, clr,
    output idx, idx_vld, locked, err, err_cnt
  );

endinterface

// File: rtl/lfsr16_lut.sv
// Combinational decode of one lfsr16 code: legality, binary index, successor.
module lfsr16_lut
  import lfsr16_tracker_pkg::*;
(
  input  logic [LFSR_W-1:0] din,
  output lut_t              res
);

  always_comb begin
    res       = '0;
    res.succ  = lfsr_succ(din);
    res.legal = 1'b1;
    case (din)
      5'b10000: res.idx = 4'd0;
      5'b00001: res.idx = 4'd1;
      5'b00011: res.idx = 4'd2;
      5'b00111: res.idx = 4'd3;
      5'b01111: res.idx = 4'd4;
      5'b11110: res.idx = 4'd5;
      5'b11101: res.idx = 4'd6;
      5'b11010: res.idx = 4'd7;
      5'b10101: res.idx = 4'd8;
      5'b01011: res.idx = 4'd9;
      5'b10110: res.idx = 4'd10;
      5'b01100: res.idx = 4'd11;
      5'b11001: res.idx = 4'd12;
      5'b10010: res.idx = 4'd13;
      5'b00100: res.idx = 4'd14;
      5'b01000: res.idx = 4'd15;
      default:  res.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/lfsr16_tracker.sv
// Tracks an lfsr16 output stream: decodes each code to its position and audits
// the sequence with a HUNT/CHECK/LOCKED FSM and a saturating error counter.
module lfsr16_tracker
  import lfsr16_tracker_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned MISS_MAX = 3,
  parameter int unsigned ERRW     = 8
) (
  input  logic               clk,
  input  logic               rst,
  lfsr16_tracker_if.slave    bus
);

  localparam logic [2:0]        LOCK_N  = 3'(LOCK_CNT);
  localparam logic [2:0]        MISS_N  = 3'(MISS_MAX);
  localparam logic [LFSR_W-1:0] EXP_RST = lfsr_succ(RESET_CODE);

  lut_t              din_lut;
  state_t            state;
  logic [2:0]        good;
  logic [2:0]        miss;
  logic [2:0]        good_inc;
  logic [2:0]        miss_inc;
  logic [LFSR_W-1:0] exp_code;
  logic [IDX_W-1:0]  idx_q;
  logic              vld_q;
  logic              locked_q;
  logic              err_q;
  logic [ERRW-1:0]   cnt_q;
  logic              match;
  logic              err_now;

  lfsr16_lut u_lut (
    .din (bus.din),
    .res (din_lut)
  );

  // The previous code is held as its expected successor, so one LUT serves
  // both decode and the successor check.
  always_comb begin
    match    = din_lut.legal && (bus.din == exp_code);
    err_now  = bus.en && (state == LOCKED) && !match;
    good_inc = good + 3'd1;
    miss_inc = miss + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      good     <= '0;
      miss     <= '0;
      exp_code <= EXP_RST;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      err_q <= err_now;
      if (bus.en) begin
        if (din_lut.legal) begin
          idx_q    <= din_lut.idx;
          vld_q    <= 1'b1;
          exp_code <= din_lut.succ;
        end
        case (state)
          HUNT: begin
            if (din_lut.legal) begin
              state <= CHECK;
              good  <= '0;
            end
          end
          CHECK: begin
            if (match) begin
              if (good_inc == LOCK_N) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
                miss     <= '0;
              end else begin
                good <= good_inc;
              end
            end else if (din_lut.legal) begin
              good <= '0;
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            if (match) begin
              miss <= '0;
            end else if (miss_inc == MISS_N) begin
              state    <= HUNT;
              locked_q <= 1'b0;
              miss     <= '0;
            end else begin
              miss <= miss_inc;
            end
          end
          default: begin
            state    <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // A clear coinciding with a fresh error leaves that error counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.clr) begin
      cnt_q <= {{(ERRW-1){1'b0}}, err_now};
    end else if (err_now && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ERRW'(1);
    end
  end

  assign bus.idx     = idx_q;
  assign bus.idx_vld = vld_q;
  assign bus.locked  = locked_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = cnt_q;

endmodule

// File: tb/tb_lfsr16_tracker.sv
// Self-checking bench for lfsr16_tracker: directed vector table, hand-written
// corner sequences and randomized stimulus against a position-based model.
module tb_lfsr16_tracker;

  localparam int LOCK_CNT = 2;
  localparam int MISS_MAX = 3;
  localparam int ERRW     = 8;
  localparam int CNT_MAX  = (1 << ERRW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lfsr16_tracker_if #(.ERRW(ERRW)) bus ();

  lfsr16_tracker #(
    .LOCK_CNT (LOCK_CNT),
    .MISS_MAX (MISS_MAX),
    .ERRW     (ERRW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // lfsr16 output sequence, indexed by position
  logic [4:0] codes [16] = '{5'b10000, 5'b00001, 5'b00011, 5'b00111,
                             5'b01111, 5'b11110, 5'b11101, 5'b11010,
                             5'b10101, 5'b01011, 5'b10110, 5'b01100,
                             5'b11001, 5'b10010, 5'b00100, 5'b01000};

  int errors = 0;
  int checks = 0;

  // model state: mode 0=hunt 1=check 2=locked; m_prev is a sequence position
  int m_mode, m_good, m_miss, m_prev;
  int m_idx, m_vld, m_locked, m_err, m_cnt;

  typedef struct {
    logic       en;
    logic [4:0] din;
    logic       clr;
    logic [3:0] idx;
    logic       vld;
    logic       locked;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pos_of(input logic [4:0] c);
    for (int i = 0; i < 16; i++)
      if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_good = 0; m_miss = 0; m_prev = 0;
    m_idx = 0; m_vld = 0; m_locked = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic en, input logic [4:0] din, input logic clr);
    int  p;
    bit  legal, match, e;
    e = 0;
    m_vld = 0;
    if (en) begin
      p     = pos_of(din);
      legal = (p >= 0);
      match = legal && (p == (m_prev + 1) % 16);
      case (m_mode)
        0: if (legal) begin m_mode = 1; m_good = 0; end
        1: begin
          if (match) begin
            m_good++;
            if (m_good == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
          end else if (legal) m_good = 0;
          else m_mode = 0;
        end
        default: begin
          if (match) m_miss = 0;
          else begin
            e = 1;
            m_miss++;
            if (m_miss == MISS_MAX) m_mode = 0;
          end
        end
      endcase
      if (legal) begin m_idx = p; m_vld = 1; m_prev = p; end
    end
    m_err = e;
    if (clr) m_cnt = e;
    else if (e && m_cnt < CNT_MAX) m_cnt++;
    m_locked = (m_mode == 2);
  endtask

  task automatic step(input logic en, input logic [4:0] din, input logic clr);
    bus.en = en; bus.din = din; bus.clr = clr;
    @(posedge clk);
    model_step(en, din, clr);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, ".idx"},     32'(bus.idx),     32'(m_idx));
    check({tag, ".idx_vld"}, 32'(bus.idx_vld), 32'(m_vld));
    check({tag, ".locked"},  32'(bus.locked),  32'(m_locked));
    check({tag, ".err"},     32'(bus.err),     32'(m_err));
    check({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(m_cnt));
  endtask

  task automatic step_check(input string tag, input logic en, input logic [4:0] din, input logic clr);
    step(en, din, clr);
    cmp_model(tag);
  endtask

  task automatic get_locked(input string tag);
    for (int i = 0; i < 40 && m_mode != 2; i++)
      step_check(tag, 1'b1, codes[(m_prev + 1) % 16], 1'b0);
    check({tag, ".lock_reached"}, 32'(bus.locked), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.din = '0; bus.clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cmp_model("reset");
    rst = 1'b0;
  endtask

  initial begin
    int start, gpos;
    logic [4:0] d;
    logic ge;
    int unsigned sel;

    //            en    din       clr   idx  vld   lck   err   cnt
    vecs[0]  = '{1'b1, 5'b10000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 5'b00001, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 5'b00011, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 5'b11111, 1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 8'd1};
    vecs[4]  = '{1'b1, 5'b00111, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 8'd1};
    vecs[5]  = '{1'b0, 5'b00000, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[6]  = '{1'b0, 5'b00000, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 5'b01111, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 5'b01111, 1'b0, 4'd4, 1'b1, 1'b1, 1'b1, 8'd1};
    vecs[9]  = '{1'b1, 5'b00000, 1'b0, 4'd4, 1'b0, 1'b1, 1'b1, 8'd2};
    vecs[10] = '{1'b1, 5'b11110, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[11] = '{1'b1, 5'b11110, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 8'd1};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].en, vecs[i].din, vecs[i].clr);
      check($sformatf("v%0d.idx", i),     32'(bus.idx),     32'(vecs[i].idx));
      check($sformatf("v%0d.idx_vld", i), 32'(bus.idx_vld), 32'(vecs[i].vld));
      check($sformatf("v%0d.locked", i),  32'(bus.locked),  32'(vecs[i].locked));
      check($sformatf("v%0d.err", i),     32'(bus.err),     32'(vecs[i].err));
      check($sformatf("v%0d.err_cnt", i), 32'(bus.err_cnt), 32'(vecs[i].cnt));
    end

    // two full laps through the 15->0 wrap
    for (int k = 0; k < 32; k++) begin
      step_check("lap", 1'b1, codes[(m_prev + 1) % 16], 1'b0);
      if (m_prev == 15) check("wrap_idx15", 32'(bus.idx), 32'd15);
      if (m_prev == 0)  check("wrap_idx0",  32'(bus.idx), 32'd0);
    end

    // MISS_MAX mismatches in a row drop lock, then relock
    get_locked("pre3");
    step_check("pre3", 1'b1, codes[(m_prev + 1) % 16], 1'b0);
    start = m_cnt;
    for (int k = 0; k < MISS_MAX; k++)
      step_check("miss3", 1'b1, codes[m_prev], 1'b0);
    check("miss3.unlocked", 32'(bus.locked), 32'd0);
    check("miss3.cnt", 32'(bus.err_cnt), 32'(start + MISS_MAX));
    for (int k = 0; k <= LOCK_CNT; k++)
      step_check("relock", 1'b1, codes[(m_prev + 1) % 16], 1'b0);
    check("relock.locked", 32'(bus.locked), 32'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 14)      d = codes[(m_prev + 1) % 16];
      else if (sel < 17) d = 5'($urandom);
      else               d = codes[m_prev];
      step_check("rand", $urandom_range(0, 5) != 0, d, $urandom_range(0, 24) == 0);
    end

    // drive err_cnt to saturation
    for (int i = 0; i < 3000 && m_cnt < CNT_MAX; i++) begin
      if (m_mode == 2 && m_miss < MISS_MAX - 1) d = codes[m_prev];
      else                                      d = codes[(m_prev + 1) % 16];
      step_check("sat", 1'b1, d, 1'b0);
    end
    check("sat.reached", 32'(bus.err_cnt), 32'(CNT_MAX));
    step_check("sat", 1'b1, codes[(m_prev + 1) % 16], 1'b0);
    step_check("sat", 1'b1, codes[m_prev], 1'b0);
    check("sat.hold", 32'(bus.err_cnt), 32'(CNT_MAX));
    check("sat.err", 32'(bus.err), 32'd1);
    step_check("clr_err", 1'b1, codes[m_prev], 1'b1);
    check("clr_err.cnt", 32'(bus.err_cnt), 32'd1);

    // asynchronous reset between edges while locked
    get_locked("prerst");
    #3;
    rst = 1'b1;
    #1;
    check("arst.idx",     32'(bus.idx),     32'd0);
    check("arst.idx_vld", 32'(bus.idx_vld), 32'd0);
    check("arst.locked",  32'(bus.locked),  32'd0);
    check("arst.err",     32'(bus.err),     32'd0);
    check("arst.err_cnt", 32'(bus.err_cnt), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
    // non-successor first code must only anchor when hunting
    step_check("post_rst", 1'b1, codes[5], 1'b0);
    check("post_rst.nolock", 32'(bus.locked), 32'd0);
    for (int k = 0; k < LOCK_CNT; k++)
      step_check("post_rst", 1'b1, codes[(m_prev + 1) % 16], 1'b0);
    check("post_rst.locked", 32'(bus.locked), 32'd1);

    // follow an lfsr16 source that advances when enabled
    do_reset();
    gpos = 0;
    for (int i = 0; i < 60; i++) begin
      ge = ($urandom_range(0, 2) != 0);
      if (ge) gpos = (gpos + 1) % 16;
      step_check("gen", ge, codes[gpos], 1'b0);
      check("gen.idx_pos", 32'(bus.idx), 32'(gpos));
    end
    check("gen.locked", 32'(bus.locked), 32'd1);
    check("gen.no_err", 32'(bus.err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
